// File: rtl/phy_tx_ctrl_if.sv
// Handshake bundle between the two requester FIFO heads, the link controller and the PHY word input.
// The master side is the controller; the slave side is the FIFOs and the PHY.
interface phy_tx_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic [DATA_W-1:0] req0_data;
    logic              req0_pop;
    logic              req1_valid;
    logic [DATA_W-1:0] req1_data;
    logic              req1_pop;
    logic [DATA_W-1:0] data_in_tx;
    logic              valid_in_tx;

    modport master (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_pop, req1_pop, data_in_tx, valid_in_tx
    );

    modport slave (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_pop, req1_pop, data_in_tx, valid_in_tx
    );
endinterface

// File: rtl/phy_tx_ctrl.sv
// Link bring-up sequencer (OFF -> INIT -> traffic) and burst-limited round-robin arbiter
// feeding one word per clock from two requester FIFOs into the PHY transmitter.
module phy_tx_ctrl #(
    parameter int DATA_W      = 32,
    parameter int INIT_CYCLES = 8,
    parameter int BURST_MAX   = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    phy_tx_ctrl_if.master bus,
    output logic          active,
    output logic          grant,
    output logic [1:0]    state_out
);
    typedef enum logic [1:0] {
        ST_OFF    = 2'b00,
        ST_INIT   = 2'b01,
        ST_IDLE   = 2'b10,
        ST_ACTIVE = 2'b11
    } state_t;

    localparam int INIT_W  = $clog2(INIT_CYCLES + 1);
    localparam int BURST_W = $clog2(BURST_MAX + 1);
    localparam logic [INIT_W-1:0]  INIT_LAST = INIT_W'(INIT_CYCLES - 1);
    localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(BURST_MAX);

    state_t             state;
    logic [INIT_W-1:0]  init_cnt;
    logic [BURST_W-1:0] burst_cnt;

    logic              traffic;
    logic              owner_valid;
    logic              other_valid;
    logic              take_owner;
    logic              take_other;
    logic              pop0;
    logic              pop1;
    logic [DATA_W-1:0] sel_data;

    // NOTE: every signal gets a value at the top of always_comb so no path leaves one unassigned (no latch).
    always_comb begin
        traffic     = 1'b0;
        owner_valid = 1'b0;
        other_valid = 1'b0;
        take_owner  = 1'b0;
        take_other  = 1'b0;
        pop0        = 1'b0;
        pop1        = 1'b0;
        sel_data    = bus.req0_data;

        traffic     = enable && (state == ST_IDLE || state == ST_ACTIVE);
        owner_valid = grant ? bus.req1_valid : bus.req0_valid;
        other_valid = grant ? bus.req0_valid : bus.req1_valid;
        // The owner keeps the slot until its burst is spent, but only if someone else is waiting.
        take_owner  = traffic && owner_valid && (burst_cnt < BURST_LIM || !other_valid);
        take_other  = traffic && other_valid && !take_owner;
        pop0        = (take_owner && !grant) || (take_other && grant);
        pop1        = (take_owner && grant) || (take_other && !grant);
        sel_data    = pop1 ? bus.req1_data : bus.req0_data;
    end

    assign bus.req0_pop = pop0;
    assign bus.req1_pop = pop1;
    assign state_out    = state;

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= ST_OFF;
            init_cnt        <= '0;
            burst_cnt       <= '0;
            grant           <= 1'b0;
            active          <= 1'b0;
            bus.data_in_tx  <= '0;
            bus.valid_in_tx <= 1'b0;
        end else begin
            bus.valid_in_tx <= 1'b0;
            case (state)
                ST_OFF: begin
                    if (enable) begin
                        state    <= ST_INIT;
                        init_cnt <= '0;
                    end
                end
                ST_INIT: begin
                    if (!enable) begin
                        state <= ST_OFF;
                    end else if (init_cnt == INIT_LAST) begin
                        state  <= ST_IDLE;
                        active <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                default: begin
                    if (!enable) begin
                        state  <= ST_OFF;
                        active <= 1'b0;
                    end else if (take_owner || take_other) begin
                        state           <= ST_ACTIVE;
                        bus.valid_in_tx <= 1'b1;
                        bus.data_in_tx  <= sel_data;
                        if (take_other) begin
                            grant     <= ~grant;
                            burst_cnt <= BURST_W'(1);
                        end else if (burst_cnt < BURST_LIM) begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                    end else begin
                        state     <= ST_IDLE;
                        burst_cnt <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_phy_tx_ctrl.sv
// Directed bench for phy_tx_ctrl: expected words are queued when a pop is expected
// and compared when the word reaches data_in_tx one clock later.
module tb_phy_tx_ctrl;
    localparam logic [1:0] OFF  = 2'b00;
    localparam logic [1:0] INIT = 2'b01;
    localparam logic [1:0] IDLE = 2'b10;
    localparam logic [1:0] ACT  = 2'b11;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       active;
    logic       grant;
    logic [1:0] state_out;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_word = '0;

    phy_tx_ctrl_if #(.DATA_W(32)) bus ();

    phy_tx_ctrl #(.DATA_W(32), .INIT_CYCLES(8), .BURST_MAX(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .bus       (bus.master),
        .active    (active),
        .grant     (grant),
        .state_out (state_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive, check pops before the edge, check registered outputs after it.
    task automatic cyc(input logic e, input logic v0, input logic [31:0] d0,
                       input logic v1, input logic [31:0] d1,
                       input logic p0, input logic p1,
                       input logic [1:0] est, input logic eg);
        @(negedge clk);
        enable         = e;
        bus.req0_valid = v0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_data  = d1;
        #1;
        check("req0_pop", 32'(bus.req0_pop), 32'(p0));
        check("req1_pop", 32'(bus.req1_pop), 32'(p1));
        if (p0) exp_q.push_back(d0);
        if (p1) exp_q.push_back(d1);
        @(posedge clk);
        #1;
        check("valid_in_tx", 32'(bus.valid_in_tx), 32'(p0 | p1));
        if ((p0 | p1) && exp_q.size() > 0) last_word = exp_q.pop_front();
        check("data_in_tx", bus.data_in_tx, last_word);
        check("state_out", 32'(state_out), 32'(est));
        check("grant", 32'(grant), 32'(eg));
        check("active", 32'(active), 32'(est[1]));
    endtask

    logic [31:0] r0 [5];
    logic [31:0] r1 [4];
    logic        seq [9];
    int          i0;
    int          i1;

    initial begin
        reset          = 1'b0;
        enable         = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.valid_in_tx), 32'd0);
        check("rst_data", bus.data_in_tx, 32'd0);
        check("rst_state", 32'(state_out), 32'(OFF));
        check("rst_grant", 32'(grant), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Bring-up: enable sampled in OFF, eight INIT cycles, then IDLE.
        cyc(1, 1, 32'hFFFFFFFF, 0, 0, 0, 0, INIT, 0);
        for (int i = 0; i < 8; i++)
            cyc(1, 1, 32'hFFFFFFFF, 0, 0, 0, 0, (i == 7) ? IDLE : INIT, 0);

        // req0 alone streams four words back to back.
        cyc(1, 1, 32'hFFFFFFFF, 0, 0, 1, 0, ACT, 0);
        cyc(1, 1, 32'hEEEEEEEE, 0, 0, 1, 0, ACT, 0);
        cyc(1, 1, 32'hDDDDDDDD, 0, 0, 1, 0, ACT, 0);
        cyc(1, 1, 32'hCCCCCCCC, 0, 0, 1, 0, ACT, 0);
        cyc(1, 0, 32'h0, 0, 0, 0, 0, IDLE, 0);

        // Both always valid: bursts of four alternate with no bubbles.
        r0  = '{32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004, 32'h00000005};
        r1  = '{32'hAAAAAAAA, 32'h99999999, 32'h88888888, 32'h77777777};
        seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        i0 = 0;
        i1 = 0;
        for (int k = 0; k < 9; k++) begin
            cyc(1, 1, r0[i0], 1, r1[(i1 < 4) ? i1 : 3], !seq[k], seq[k], ACT, seq[k]);
            if (seq[k]) i1++;
            else i0++;
        end
        cyc(1, 0, 0, 0, 0, 0, 0, IDLE, 0);

        // req1 streams; req0 arrives after two words and waits for the burst to finish.
        cyc(1, 0, 32'h50000001, 1, 32'h51000001, 0, 1, ACT, 1);
        cyc(1, 0, 32'h50000001, 1, 32'h51000002, 0, 1, ACT, 1);
        cyc(1, 1, 32'h50000001, 1, 32'h51000003, 0, 1, ACT, 1);
        cyc(1, 1, 32'h50000001, 1, 32'h51000004, 0, 1, ACT, 1);
        cyc(1, 1, 32'h50000001, 1, 32'h51000005, 1, 0, ACT, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, IDLE, 0);

        // req1 drops after two words; req0 takes over at once.
        cyc(1, 0, 32'h52000001, 1, 32'h53000001, 0, 1, ACT, 1);
        cyc(1, 0, 32'h52000001, 1, 32'h53000002, 0, 1, ACT, 1);
        cyc(1, 1, 32'h52000001, 0, 32'h53000003, 1, 0, ACT, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, IDLE, 0);

        // Disable during traffic, then re-enable through a full INIT window.
        cyc(1, 1, 32'h600D0001, 0, 0, 1, 0, ACT, 0);
        cyc(0, 1, 32'h600D0002, 0, 0, 0, 0, OFF, 0);
        cyc(0, 1, 32'h600D0002, 0, 0, 0, 0, OFF, 0);
        cyc(1, 1, 32'h600D0002, 0, 0, 0, 0, INIT, 0);
        for (int i = 0; i < 8; i++)
            cyc(1, 1, 32'h600D0002, 0, 0, 0, 0, (i == 7) ? IDLE : INIT, 0);
        cyc(1, 1, 32'h600D0002, 0, 0, 1, 0, ACT, 0);
        cyc(1, 0, 32'h0, 1, 32'h700D0001, 0, 1, ACT, 1);

        // Asynchronous reset while a word is on the PHY input and req1 owns the slot.
        @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.valid_in_tx), 32'd0);
        check("mid_rst_data", bus.data_in_tx, 32'd0);
        check("mid_rst_state", 32'(state_out), 32'(OFF));
        check("mid_rst_grant", 32'(grant), 32'd0);
        check("mid_rst_pop0", 32'(bus.req0_pop), 32'd0);
        check("mid_rst_pop1", 32'(bus.req1_pop), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/phy_tx_ctrl.md
Name: phy_tx_ctrl

Overview:
Link controller and arbiter that feeds the 32-bit parallel input (data_in_tx/valid_in_tx) of the two-lane PHY transmitter.
- Sequences link bring-up: OFF, then a fixed INIT window, then traffic.
- Shares the single PHY TX word slot between two requester queues with burst-limited round-robin.
- Sits between the two upstream FIFOs and phy_tx, in the clk_2f word-clock domain (connected to "clk" here).

Parameters:
DATA_W, 32, word width of requester and PHY data.
INIT_CYCLES, 8, cycles spent in INIT before traffic is allowed (>=1).
BURST_MAX, 4, max consecutive words one requester sends while the other is waiting (>=1).

Ports:
clk  input  1  word clock; all state changes on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
enable  input  1  link enable.
req0_valid  input  1  requester 0 has a word at its head.
req0_data  input  DATA_W  requester 0 head word.
req0_pop  output  1  combinational; requester 0 head consumed this cycle.
req1_valid  input  1  requester 1 has a word at its head.
req1_data  input  DATA_W  requester 1 head word.
req1_pop  output  1  combinational; requester 1 head consumed this cycle.
data_in_tx  output  DATA_W  registered word to PHY.
valid_in_tx  output  1  registered; data_in_tx is valid.
active  output  1  registered; link in IDLE or ACTIVE.
grant  output  1  registered; current owner (0/1).
state_out  output  2  encoding: OFF=00, INIT=01, IDLE=10, ACTIVE=11.

Behaviour:
- Reset (reset=0, asynchronous): state OFF, data_in_tx=0, valid_in_tx=0, active=0, grant=0, burst_cnt=0, init_cnt=0. Pops are 0 while reset is asserted. Reset mid-transfer drops the in-flight word with no recovery.
- OFF: all pops 0, valid_in_tx=0. If enable=1, go to INIT next cycle with init_cnt=0.
- INIT: pops 0, valid_in_tx=0, init_cnt increments each cycle. At init_cnt==INIT_CYCLES-1, go to IDLE. INIT therefore lasts exactly INIT_CYCLES cycles.
- IDLE/ACTIVE: active=1. Each cycle, a selection is made combinationally from valid, grant and burst_cnt; exactly one pop or none.
  - Pops are only asserted when enable=1.
  - A pop in cycle t gives data_in_tx <= selected data and valid_in_tx=1 at t+1 (latency 1), and state -> ACTIVE.
  - No pop: valid_in_tx=0 at t+1, data_in_tx holds its last value, state -> IDLE.
- Arbitration (owner = grant):
  - owner valid and (burst_cnt<BURST_MAX or other not valid): pop owner, burst_cnt+1, saturating at BURST_MAX.
  - owner valid, burst_cnt==BURST_MAX, other valid: pop other, grant<=other, burst_cnt<=1.
  - owner not valid, other valid: pop other, grant<=other, burst_cnt<=1.
  - neither valid: no pop, grant held, burst_cnt<=0.
  - After reset, grant=0, so req0 wins a simultaneous first request.
- enable=0 in INIT/IDLE/ACTIVE: pops 0 that cycle, state -> OFF next cycle, valid_in_tx=0 next cycle. The word popped in the previous cycle still appears on data_in_tx (already registered).
- enable=1 while OFF restarts the full INIT window; INIT is never skipped.
- Pops never depend on phy_tx backpressure; the PHY accepts one word per clk.

Test Plan:
1. Assert reset=0 mid-ACTIVE with valid_in_tx=1 -> same instant: valid_in_tx=0, data_in_tx=0, state_out=00, pops 0, grant=0.
2. enable=1 sampled at edge t in OFF, INIT_CYCLES=8 -> state_out=01 for t+1..t+8, 10 at t+9. req0_valid=1 since t yields first req0_pop at t+9 and valid_in_tx=1 at t+10.
3. req0 only, words 0xFFFFFFFF, 0xEEEEEEEE, 0xDDDDDDDD, 0xCCCCCCCC on consecutive cycles -> same four words on data_in_tx on consecutive cycles, one cycle after each pop. grant=0 throughout; then valid_in_tx=0 and state IDLE.
4. Both requesters always valid, BURST_MAX=4 -> pop sequence 0,0,0,0,1,1,1,1,0,... Owner words 0x00000003/0x00000004 vs 0xAAAAAAAA/0x99999999 appear in that order, with no bubble cycles.
5. req1 streaming; req0 becomes valid after req1's second word -> req1 continues to 4 words, then req0 is granted. Separately, req1 dropping valid after 2 words -> req0 is granted the next cycle.
6. enable=0 during ACTIVE -> no pop that cycle, last popped word still output, then valid_in_tx=0 and state OFF. Re-enable -> full 8-cycle INIT before the next pop.
